flash_read_arbiter: RTL and testbench
=====================================

// Module: flash_read_arbiter
// PURPOSE
//  Shares the single SPI flash between two read requesters (0 = CPU, 1 = loader DMA).
//  Sequences each read as one SPI mode-0 transaction: command, 24-bit address,
//  optional dummy byte, 4 data bytes. Returns one 32-bit word per request.
//  Sits between the CPU/loader bus logic and the flash_csn/sck/mosi/miso pins.
// PARAMETERS
//  CSN_HIGH_CYCLES  2      minimum clk_1x cycles csn stays high between transactions (>=1)
//  READ_CMD         8'h03  opcode for a normal read (used when FLASH_FAST_READ_EN is undefined)
// PORTS
//  clk_1x         in   1   system clock; all logic is on its rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  req_valid      in   2   per-requester request; held until accepted
//  req_addr       in   48  {addr1[23:0], addr0[23:0]} byte address per requester
//  req_ready      out  2   one-hot accept strobe; a request is accepted on valid&ready
//  rdata          out  32  read word, shared by both requesters
//  rdata_valid    out  2   one-hot 1-cycle pulse marking rdata for the owning requester
//  flash_csn      out  1   flash chip select, active low
//  flash_sck      out  1   SPI clock (clk_1x/2 while active, idle low)
//  flash_mosi     out  1   serial data to flash, MSB first
//  flash_miso     in   1   serial data from flash
// BEHAVIOUR
//  Reset (async): flash_csn=1, flash_sck=0, flash_mosi=0, req_ready=0, rdata_valid=0,
//   rdata=0, state=IDLE, round-robin pointer = requester 0, gap counter = 0.
//  States: IDLE -> CMD(8b) -> ADDR(24b) -> [DUMMY(8b)] -> DATA(32b) -> GAP -> IDLE.
//  IDLE: req_ready is combinational from req_valid, state and the pointer; at most one bit set.
//   If both requesters are valid, the pointer's requester wins. After each grant the pointer
//   moves to the other requester. A single valid requester wins regardless of the pointer.
//  Accept cycle t0: latch the address and the owner. flash_csn falls at t0+1.
//  Bit timing: every bit lasts 2 cycles. Phase A drives sck=0 and updates mosi.
//   Phase B drives sck=1; miso is sampled in the cycle in which sck rises.
//  CMD/ADDR/DUMMY: shift the opcode, then addr[23:0], then 8'h00, all MSB first.
//  DATA: 4 bytes, each MSB first. Byte k goes to rdata[8k+7:8k] (little-endian word).
//   mosi is held 0 during DATA.
//  Completion: csn rises, sck=0, and rdata_valid[owner] pulses at t0+129
//   (t0+145 with fast read). rdata holds its value until the next completion.
//  GAP: csn stays high for CSN_HIGH_CYCLES cycles, counted from the csn rise. The earliest
//   next accept is at t0+129+CSN_HIGH_CYCLES (fast read: t0+145+CSN_HIGH_CYCLES).
//  While not in IDLE: req_ready=0. A request arriving mid-transaction waits.
//  A request withdrawn before acceptance is simply not served. No error is flagged.
//  Addresses pass through unmodified. 24'hFFFFFC reads the last 4 bytes, and
//   24'hFFFFFE wraps to 0 inside the flash. The block does no wrap handling.
//  Async reset mid-transaction: csn goes high at once and no rdata_valid is issued.
//   The aborted request is lost.
// CONFIGURATION
//  `FLASH_FAST_READ_EN defined: opcode 8'h0B, with the DUMMY state (8 bits) inserted.
//   Latency rises by 16 cycles.
//  Undefined: opcode READ_CMD, DUMMY state skipped.
// STRUCTURE
//  Package flash_ctrl_pkg: the state enum (IDLE, CMD, ADDR, DUMMY, DATA, GAP) and the
//   opcode constants FLASH_CMD_READ=8'h03 and FLASH_CMD_FAST_READ=8'h0B.
//   It also holds the bit-count constants CMD_BITS=8, ADDR_BITS=24, DUMMY_BITS=8, DATA_BITS=32.
//  Sub-module flash_spi_shifter holds the phase toggle, sck/mosi generation, the 32-bit
//   shift-out register, the 32-bit shift-in register and the bit counter with a done strobe.
//   The top level holds the arbiter, the pointer, the state machine and the GAP counter.
// TESTING (bench: sim_spiflash loaded with byte[i] = i[7:0])
//  1 Single read: req0 at addr 24'h000010 -> rdata_valid[0] at t0+129 with rdata=32'h13121110.
//    csn is low for exactly 128 cycles.
//  2 Contention: both valid from reset -> req 0 served first, then req 1 (addr 24'h000100
//    -> 32'h03020100). The next accept comes no earlier than CSN_HIGH_CYCLES after the csn rise.
//  3 Fairness: both held valid for 6 grants -> the grants alternate 0,1,0,1,0,1.
//  4 Fast read: compile with `FLASH_FAST_READ_EN -> mosi shows 8'h0B, addr, then 8 zero bits.
//    Data arrives at t0+145.
//  5 Reset abort: assert reset_n low during ADDR -> csn=1 and sck=0 at once, no rdata_valid.
//    A fresh read after release returns correct data.
//  6 Boundary: addr 24'hFFFFFC -> 32'hFFFEFDFC. req1 raised mid-transaction sees req_ready=0
//    until GAP ends.

Source files
------------

// File: rtl/flash_ctrl_pkg.sv
// flash_ctrl_pkg: shared types and constants for the SPI flash read path.
// Holds the sequencer state encoding, flash opcodes and the bit length of
// each transaction segment.
`timescale 1ns/1ps
package flash_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        GAP
    } flash_state_t;

    localparam logic [7:0] FLASH_CMD_READ      = 8'h03;
    localparam logic [7:0] FLASH_CMD_FAST_READ = 8'h0B;

    localparam int unsigned CMD_BITS   = 8;
    localparam int unsigned ADDR_BITS  = 24;
    localparam int unsigned DUMMY_BITS = 8;
    localparam int unsigned DATA_BITS  = 32;

endpackage

// File: rtl/flash_spi_shifter.sv
// flash_spi_shifter: SPI mode-0 bit engine.
// Each bit takes two clk_1x cycles: phase A (sck low, mosi updated) and
// phase B (sck high, miso sampled at the end of the cycle). A segment of
// up to 32 bits is loaded MSB-first; done pulses during phase B of its last
// bit so the next segment can be loaded in that same cycle with no gap.
`timescale 1ns/1ps
module flash_spi_shifter (
    input  logic        clk_1x,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [5:0]  load_bits,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        done,
    output logic [31:0] rx_word
);

    logic        active;
    logic        phase_b;
    logic [5:0]  bit_cnt;
    logic [31:0] tx_sh;
    logic [31:0] rx_sh;

    assign sck     = phase_b;
    assign mosi    = tx_sh[31];
    assign done    = active && phase_b && (bit_cnt == 6'd0);
    // rx_word already contains the bit being sampled this cycle, so the
    // owner can capture a complete word on the done strobe.
    assign rx_word = {rx_sh[30:0], miso};

    // Phase toggle, bit counter and shift-out register.
    always_ff @(posedge clk_1x or negedge reset_n) begin
        if (!reset_n) begin
            active  <= 1'b0;
            phase_b <= 1'b0;
            bit_cnt <= 6'd0;
            tx_sh   <= 32'd0;
        end else if (load) begin
            active  <= 1'b1;
            phase_b <= 1'b0;
            bit_cnt <= load_bits - 6'd1;
            tx_sh   <= load_data;
        end else if (active) begin
            if (!phase_b) begin
                phase_b <= 1'b1;
            end else begin
                phase_b <= 1'b0;
                if (bit_cnt == 6'd0) begin
                    active <= 1'b0;
                    tx_sh  <= 32'd0;
                end else begin
                    bit_cnt <= bit_cnt - 6'd1;
                    tx_sh   <= {tx_sh[30:0], 1'b0};
                end
            end
        end
    end

    // Shift-in register: capture miso at the end of every sck-high cycle.
    always_ff @(posedge clk_1x) begin
        if (active && phase_b) begin
            rx_sh <= rx_word;
        end
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: shares one SPI flash between the CPU (requester 0)
// and the loader DMA (requester 1). Each accepted request becomes one read
// transaction: opcode, 24-bit address, optional dummy byte, 4 data bytes,
// returned as a little-endian 32-bit word.
// Build option: define FLASH_FAST_READ_EN to use opcode 8'h0B with an 8-bit
// dummy phase (16 cycles more latency); otherwise READ_CMD with no dummy.
`timescale 1ns/1ps
module flash_read_arbiter
    import flash_ctrl_pkg::*;
#(
    parameter int unsigned CSN_HIGH_CYCLES = 2,
    parameter logic [7:0]  READ_CMD        = FLASH_CMD_READ
) (
    input  logic        clk_1x,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    input  logic [47:0] req_addr,
    output logic [1:0]  req_ready,
    output logic [31:0] rdata,
    output logic [1:0]  rdata_valid,
    output logic        flash_csn,
    output logic        flash_sck,
    output logic        flash_mosi,
    input  logic        flash_miso
);

`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] OPCODE = FLASH_CMD_FAST_READ;
`else
    localparam logic [7:0] OPCODE = READ_CMD;
`endif

    localparam int unsigned      GAP_W    = (CSN_HIGH_CYCLES > 1) ? $clog2(CSN_HIGH_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CSN_HIGH_CYCLES - 1);

    flash_state_t     state;
    flash_state_t     state_nxt;
    logic             ptr;
    logic             owner;
    logic             grant_idx;
    logic             accept;
    logic [23:0]      addr_q;
    logic [GAP_W-1:0] gap_cnt;

    logic             sh_load;
    logic [31:0]      sh_data;
    logic [5:0]       sh_bits;
    logic             sh_done;
    logic [31:0]      sh_rx;

    // Flash sends byte 0 first; it belongs in the least significant byte.
    function automatic logic [31:0] to_le_word(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    flash_spi_shifter u_shifter (
        .clk_1x    (clk_1x),
        .reset_n   (reset_n),
        .load      (sh_load),
        .load_data (sh_data),
        .load_bits (sh_bits),
        .miso      (flash_miso),
        .sck       (flash_sck),
        .mosi      (flash_mosi),
        .done      (sh_done),
        .rx_word   (sh_rx)
    );

    // State register.
    always_ff @(posedge clk_1x or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, next state, and loading of the next segment into the
    // shifter on the cycle the previous one finishes.
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        grant_idx = 1'b0;
        accept    = 1'b0;
        sh_load   = 1'b0;
        sh_data   = 32'd0;
        sh_bits   = 6'd0;
        case (state)
            IDLE: begin
                if (req_valid == 2'b11) begin
                    grant_idx = ptr;
                end else begin
                    grant_idx = req_valid[1];
                end
                if (req_valid != 2'b00) begin
                    accept    = 1'b1;
                    req_ready = grant_idx ? 2'b10 : 2'b01;
                    state_nxt = CMD;
                    sh_load   = 1'b1;
                    sh_data   = {OPCODE, 24'd0};
                    sh_bits   = 6'(CMD_BITS);
                end
            end
            CMD: begin
                if (sh_done) begin
                    state_nxt = ADDR;
                    sh_load   = 1'b1;
                    sh_data   = {addr_q, 8'd0};
                    sh_bits   = 6'(ADDR_BITS);
                end
            end
            ADDR: begin
                if (sh_done) begin
                    sh_load = 1'b1;
`ifdef FLASH_FAST_READ_EN
                    state_nxt = DUMMY;
                    sh_bits   = 6'(DUMMY_BITS);
`else
                    state_nxt = DATA;
                    sh_bits   = 6'(DATA_BITS);
`endif
                end
            end
            DUMMY: begin
                if (sh_done) begin
                    state_nxt = DATA;
                    sh_load   = 1'b1;
                    sh_bits   = 6'(DATA_BITS);
                end
            end
            DATA: begin
                if (sh_done) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pointer, owner, chip select, gap counter and the returned word.
    always_ff @(posedge clk_1x or negedge reset_n) begin
        if (!reset_n) begin
            ptr         <= 1'b0;
            owner       <= 1'b0;
            flash_csn   <= 1'b1;
            gap_cnt     <= '0;
            rdata       <= 32'd0;
            rdata_valid <= 2'b00;
        end else begin
            rdata_valid <= 2'b00;
            if (accept) begin
                ptr       <= ~grant_idx;
                owner     <= grant_idx;
                flash_csn <= 1'b0;
            end
            if (state == DATA && sh_done) begin
                flash_csn   <= 1'b1;
                rdata       <= to_le_word(sh_rx);
                rdata_valid <= owner ? 2'b10 : 2'b01;
            end
            if (state == GAP) begin
                gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
            end
        end
    end

    // Address of the winning requester, held for the whole transaction.
    always_ff @(posedge clk_1x) begin
        if (accept) begin
            addr_q <= grant_idx ? req_addr[47:24] : req_addr[23:0];
        end
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter: self-checking bench for flash_read_arbiter with a
// behavioural SPI flash whose byte[i] = i[7:0]. Honours FLASH_FAST_READ_EN.
`timescale 1ns/1ps
module tb_flash_read_arbiter;

    localparam int CSN_HIGH = 3;
`ifdef FLASH_FAST_READ_EN
    localparam int         LAT = 145;
    localparam int         HDR = 40;
    localparam logic [7:0] OPC = 8'h0B;
`else
    localparam int         LAT = 129;
    localparam int         HDR = 32;
    localparam logic [7:0] OPC = 8'h03;
`endif

    logic        clk_1x = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [47:0] req_addr;
    logic [1:0]  req_ready;
    logic [31:0] rdata;
    logic [1:0]  rdata_valid;
    logic        flash_csn;
    logic        flash_sck;
    logic        flash_mosi;
    logic        fmiso = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed { logic [1:0] who; logic [31:0] cyc; logic [23:0] addr; } acc_t;
    typedef struct packed { logic [1:0] who; logic [31:0] data; logic [31:0] cyc; logic [31:0] low; } cpl_t;
    typedef struct packed { logic [1:0] who; logic [31:0] data; } exp_t;

    acc_t acc_q[$];
    cpl_t cpl_q[$];
    exp_t exp_q[$];

    flash_read_arbiter #(.CSN_HIGH_CYCLES(CSN_HIGH)) dut (
        .clk_1x      (clk_1x),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .flash_csn   (flash_csn),
        .flash_sck   (flash_sck),
        .flash_mosi  (flash_mosi),
        .flash_miso  (fmiso)
    );

    always #5 clk_1x = ~clk_1x;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk_1x) cyc <= cyc + 32'd1;

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        logic [7:0] b0;
        b0 = a[7:0];
        return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
    endfunction

    function automatic logic data_bit(input logic [23:0] a, input int d);
        logic [7:0] b;
        b = a[7:0] + 8'(d / 8);
        return b[7 - (d % 8)];
    endfunction

    // Flash model, evaluated mid-cycle from the observed pin levels.
    int          fbit = 0;
    logic        sck_d = 1'b0;
    logic [7:0]  f_cmd = 8'd0;
    logic [23:0] f_addr = 24'd0;
    logic [7:0]  f_dummy = 8'd0;
    logic        f_mosi_nz = 1'b0;
    always @(negedge clk_1x) begin
        sck_d <= flash_sck;
        if (flash_csn) begin
            fbit <= 0;
        end else if (flash_sck && !sck_d) begin
            if (fbit == 0) f_mosi_nz <= 1'b0;
            if (fbit < 8) f_cmd <= {f_cmd[6:0], flash_mosi};
            else if (fbit < 32) f_addr <= {f_addr[22:0], flash_mosi};
            else if (fbit < HDR) f_dummy <= {f_dummy[6:0], flash_mosi};
            else if (flash_mosi !== 1'b0) f_mosi_nz <= 1'b1;
            fbit <= fbit + 1;
        end else if (!flash_sck && sck_d && fbit >= HDR && fbit < HDR + 32) begin
            fmiso <= data_bit(f_addr, fbit - HDR);
        end
    end

    // Records accepts and completions for the scoreboard.
    int low_run = 0;
    always @(negedge clk_1x) begin
        if (reset_n && (req_valid & req_ready) != 2'b00)
            acc_q.push_back({req_valid & req_ready, cyc,
                             req_ready[1] ? req_addr[47:24] : req_addr[23:0]});
        if (rdata_valid != 2'b00)
            cpl_q.push_back({rdata_valid, rdata, cyc, 32'(low_run)});
        if (!flash_csn) low_run <= low_run + 1;
        else            low_run <= 0;
    end

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk_1x);
        #1;
        acc_q.delete();
        cpl_q.delete();
        exp_q.delete();
        reset_n = 1'b1;
    endtask

    task automatic wait_cpl(input int n, input int budget, input bit hold, output bit ok);
        logic [1:0] acc;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_1x);
            acc = req_valid & req_ready;
            @(posedge clk_1x);
            #1;
            if (!hold) req_valid = req_valid & ~acc;
            if (cpl_q.size() >= n && acc_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_acc(input int n, input int budget, output bit ok);
        logic [1:0] acc;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_1x);
            acc = req_valid & req_ready;
            @(posedge clk_1x);
            #1;
            req_valid = req_valid & ~acc;
            if (acc_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_addr  = 48'd0;
        repeat (2) @(posedge clk_1x);
        @(negedge clk_1x);
        n_tests++; if (flash_csn !== 1'b1) begin n_fail++; $display("FAIL reset_csn: got %b want 1", flash_csn); end
        n_tests++; if (flash_sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b want 0", flash_sck); end
        n_tests++; if (flash_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", flash_mosi); end
        n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        n_tests++; if (rdata_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", rdata_valid); end
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    endtask

    task automatic test_single_read();
        bit ok; acc_t a; cpl_t c; exp_t e;
        do_reset();
        req_addr[23:0] = 24'h000010;
        req_valid = 2'b01;
        exp_q.push_back({2'b01, 32'h13121110});
        wait_cpl(1, 400, 1'b0, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL single_timeout: completions %0d want 1", cpl_q.size());
        end else begin
            a = acc_q.pop_front(); c = cpl_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (c.who !== e.who) begin n_fail++; $display("FAIL single_owner: got %b want %b", c.who, e.who); end
            n_tests++; if (c.data !== e.data) begin n_fail++; $display("FAIL single_data: got %h want %h", c.data, e.data); end
            n_tests++; if (c.cyc - a.cyc !== 32'(LAT)) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", c.cyc - a.cyc, LAT); end
            n_tests++; if (c.low !== 32'(LAT - 1)) begin n_fail++; $display("FAIL single_csn_low: got %0d want %0d", c.low, LAT - 1); end
            n_tests++; if (f_cmd !== OPC) begin n_fail++; $display("FAIL single_opcode: got %h want %h", f_cmd, OPC); end
            n_tests++; if (f_addr !== 24'h000010) begin n_fail++; $display("FAIL single_addr: got %h want 000010", f_addr); end
            n_tests++; if (f_mosi_nz !== 1'b0) begin n_fail++; $display("FAIL single_mosi_data: got %b want 0", f_mosi_nz); end
`ifdef FLASH_FAST_READ_EN
            n_tests++; if (f_dummy !== 8'h00) begin n_fail++; $display("FAIL fast_dummy: got %h want 00", f_dummy); end
`endif
        end
    endtask

    task automatic test_contention();
        bit ok; acc_t a0, a1; cpl_t c0, c1; exp_t e0, e1;
        req_addr  = {24'h000100, 24'h000040};
        req_valid = 2'b11;
        do_reset();
        exp_q.push_back({2'b01, exp_word(24'h000040)});
        exp_q.push_back({2'b10, 32'h03020100});
        wait_cpl(2, 800, 1'b0, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL contention_timeout: completions %0d want 2", cpl_q.size());
        end else begin
            a0 = acc_q.pop_front(); a1 = acc_q.pop_front();
            c0 = cpl_q.pop_front(); c1 = cpl_q.pop_front();
            e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
            n_tests++; if (c0.who !== e0.who) begin n_fail++; $display("FAIL contention_first: got %b want %b", c0.who, e0.who); end
            n_tests++; if (c0.data !== e0.data) begin n_fail++; $display("FAIL contention_data0: got %h want %h", c0.data, e0.data); end
            n_tests++; if (c1.who !== e1.who) begin n_fail++; $display("FAIL contention_second: got %b want %b", c1.who, e1.who); end
            n_tests++; if (c1.data !== e1.data) begin n_fail++; $display("FAIL contention_data1: got %h want %h", c1.data, e1.data); end
            n_tests++; if (a1.cyc - c0.cyc !== 32'(CSN_HIGH)) begin n_fail++; $display("FAIL contention_gap: got %0d want %0d", a1.cyc - c0.cyc, CSN_HIGH); end
            n_tests++; if (a1.cyc - a0.cyc !== 32'(LAT + CSN_HIGH)) begin n_fail++; $display("FAIL contention_accept_spacing: got %0d want %0d", a1.cyc - a0.cyc, LAT + CSN_HIGH); end
        end
    endtask

    task automatic test_fairness();
        bit ok; acc_t a; cpl_t c; exp_t e;
        req_valid = 2'b00;
        do_reset();
        req_addr  = {24'h000A80, 24'h000400};
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) exp_q.push_back({2'b01, exp_word(24'h000400)});
            else            exp_q.push_back({2'b10, exp_word(24'h000A80)});
        end
        wait_cpl(6, 1200, 1'b1, ok);
        req_valid = 2'b00;
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL fairness_timeout: completions %0d want 6", cpl_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                a = acc_q.pop_front(); c = cpl_q.pop_front(); e = exp_q.pop_front();
                n_tests++; if (a.who !== e.who) begin n_fail++; $display("FAIL fairness_grant%0d: got %b want %b", i, a.who, e.who); end
                n_tests++; if (c.data !== e.data) begin n_fail++; $display("FAIL fairness_data%0d: got %h want %h", i, c.data, e.data); end
            end
        end
    endtask

    task automatic test_reset_abort();
        bit ok; acc_t a; cpl_t c; exp_t e;
        req_valid = 2'b00;
        do_reset();
        req_addr[23:0] = 24'h000020;
        req_valid = 2'b01;
        wait_acc(1, 20, ok);
        repeat (30) @(posedge clk_1x);
        #1;
        reset_n = 1'b0;
        #1;
        n_tests++; if (flash_csn !== 1'b1) begin n_fail++; $display("FAIL abort_csn: got %b want 1", flash_csn); end
        n_tests++; if (flash_sck !== 1'b0) begin n_fail++; $display("FAIL abort_sck: got %b want 0", flash_sck); end
        repeat (3) @(posedge clk_1x);
        #1;
        reset_n = 1'b1;
        wait_cpl(1, 200, 1'b0, ok);
        n_tests++; if (cpl_q.size() != 0) begin n_fail++; $display("FAIL abort_no_rvalid: got %0d completions want 0", cpl_q.size()); end
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL abort_rdata: got %h want 0", rdata); end
        acc_q.delete(); cpl_q.delete();
        req_addr[23:0] = 24'h000030;
        req_valid = 2'b01;
        exp_q.push_back({2'b01, 32'h33323130});
        wait_cpl(1, 400, 1'b0, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL abort_fresh_timeout: completions %0d want 1", cpl_q.size());
        end else begin
            a = acc_q.pop_front(); c = cpl_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (c.data !== e.data) begin n_fail++; $display("FAIL abort_fresh_data: got %h want %h", c.data, e.data); end
            n_tests++; if (c.cyc - a.cyc !== 32'(LAT)) begin n_fail++; $display("FAIL abort_fresh_latency: got %0d want %0d", c.cyc - a.cyc, LAT); end
        end
    endtask

    task automatic test_boundary();
        bit ok; acc_t a0, a1; cpl_t c0, c1; exp_t e0, e1;
        req_valid = 2'b00;
        do_reset();
        req_addr[23:0] = 24'hFFFFFC;
        req_valid = 2'b01;
        exp_q.push_back({2'b01, 32'hFFFEFDFC});
        wait_acc(1, 20, ok);
        repeat (20) @(posedge clk_1x);
        #1;
        req_addr[47:24] = 24'h000100;
        req_valid = req_valid | 2'b10;
        exp_q.push_back({2'b10, 32'h03020100});
        @(negedge clk_1x);
        n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL boundary_busy_ready: got %b want 00", req_ready); end
        @(posedge clk_1x);
        #1;
        wait_cpl(2, 800, 1'b0, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL boundary_timeout: completions %0d want 2", cpl_q.size());
        end else begin
            a0 = acc_q.pop_front(); a1 = acc_q.pop_front();
            c0 = cpl_q.pop_front(); c1 = cpl_q.pop_front();
            e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
            n_tests++; if (c0.data !== e0.data) begin n_fail++; $display("FAIL boundary_data: got %h want %h", c0.data, e0.data); end
            n_tests++; if (a1.who !== e1.who) begin n_fail++; $display("FAIL boundary_second_owner: got %b want %b", a1.who, e1.who); end
            n_tests++; if (a1.cyc - a0.cyc !== 32'(LAT + CSN_HIGH)) begin n_fail++; $display("FAIL boundary_wait: got %0d want %0d", a1.cyc - a0.cyc, LAT + CSN_HIGH); end
            n_tests++; if (c1.data !== e1.data) begin n_fail++; $display("FAIL boundary_second_data: got %h want %h", c1.data, e1.data); end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_fairness();
        test_reset_abort();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
